// File: rtl/tx_msg_ctrl.sv
// Streams a fixed ASCII message to a UART TX port and arbitrates core stores to that port.
// Optional feature: define TX_MSG_CTRL_FIFO_EN for a 4-entry core-byte FIFO instead of a single byte register.
module tx_msg_ctrl #(
  parameter int                   MSG_LEN   = 8,
  parameter logic [8*MSG_LEN-1:0] MSG       = 64'h3230323430303031,
  parameter logic [31:0]          UART_ADDR = 32'h30000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic        tx_ready_i,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  output logic        hold_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [1:0] {S_IDLE, S_MSG, S_CORE} state_t;

  localparam logic [3:0] LAST_IDX = 4'(MSG_LEN - 1);

  state_t     state, state_next;
  logic [3:0] idx, idx_next;
  logic       done_q;
  logic       core_wr;
  logic       xfer;
  logic       core_pending;
  logic [7:0] core_byte;
  logic [7:0] msg_byte;

  assign core_wr = mem_req_i & mem_we_i & (mem_addr_i == UART_ADDR);
  assign xfer    = tx_valid_o & tx_ready_i;

`ifdef TX_MSG_CTRL_FIFO_EN
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic       full, push, pop;

  assign full         = (count == 3'd4);
  assign push         = core_wr & ~full;
  assign pop          = (state == S_CORE) & xfer;
  assign hold_o       = core_wr & full;
  assign core_pending = (count != 3'd0);
  assign core_byte    = fifo_mem[rd_ptr];

  // Full is judged before a same-cycle pop, so a freed slot is offered one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= mem_wdata_i[7:0];
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end
`else
  logic [7:0] core_q;
  logic       accept;

  // A core store is only taken from IDLE, and a simultaneous start request wins.
  assign accept       = (state == S_IDLE) & ~start_i & core_wr;
  assign hold_o       = core_wr & ~accept;
  assign core_pending = core_wr;
  assign core_byte    = core_q;

  always_ff @(posedge clk) begin
    if (rst)         core_q <= 8'h00;
    else if (accept) core_q <= mem_wdata_i[7:0];
  end
`endif

  // Index 0 selects the most significant byte of MSG.
  always_comb begin
    msg_byte = 8'h00;
    for (int i = 0; i < MSG_LEN; i++) begin
      if (idx == i[3:0]) msg_byte = MSG[8*(MSG_LEN-1-i) +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      idx    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_next;
      idx    <= idx_next;
      done_q <= (state == S_MSG) & xfer & (idx == LAST_IDX);
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          state_next = S_MSG;
          idx_next   = '0;
        end else if (core_pending) begin
          state_next = S_CORE;
        end
      end
      S_MSG: begin
        if (xfer) begin
          if (idx == LAST_IDX) begin
            state_next = S_IDLE;
            idx_next   = '0;
          end else begin
            idx_next = idx + 4'd1;
          end
        end
      end
      S_CORE: begin
        if (xfer) state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
        idx_next   = '0;
      end
    endcase
  end

  always_comb begin
    tx_valid_o = 1'b0;
    tx_data_o  = 8'h00;
    case (state)
      S_MSG: begin
        tx_valid_o = 1'b1;
        tx_data_o  = msg_byte;
      end
      S_CORE: begin
        tx_valid_o = 1'b1;
        tx_data_o  = core_byte;
      end
      default: begin
        tx_valid_o = 1'b0;
        tx_data_o  = 8'h00;
      end
    endcase
  end

  assign busy_o = (state == S_MSG);
  assign done_o = done_q;

endmodule
